// File: rtl/mmul_param_if.sv
// Bus bundle for mmul_param: operation request, operand matrices and result/status.
interface mmul_param_if #(
    parameter int N = 3,
    parameter int W = 8
);
    logic               start;
    logic               acc_mode;
    logic               sat_mode;
    logic [N*N*W-1:0]   mat_a;
    logic [N*N*W-1:0]   mat_b;
    logic [N*N*W-1:0]   mat_c;
    logic               busy;
    logic               done;
    logic               ovf;

    modport master (output start, acc_mode, sat_mode, mat_a, mat_b,
                    input  mat_c, busy, done, ovf);
    modport slave  (input  start, acc_mode, sat_mode, mat_a, mat_b,
                    output mat_c, busy, done, ovf);
endinterface

// File: rtl/mmul_param.sv
// Sequential signed NxN matrix multiplier, one MAC per cycle, with optional
// accumulate into the previous result and wrap/saturate reduction to W bits.
module mmul_param #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    mmul_param_if.slave  bus
);
    localparam int NN = N * N * W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = 2 * W + $clog2(N) + 1;
    localparam logic signed [AW-1:0] MAXV = AW'((1 << (W - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = AW'(-(1 << (W - 1)));
    localparam logic [IW-1:0]        LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [NN-1:0]          a_q, b_q, shadow_q, shadow_d, mat_c_q;
    logic                   acc_mode_q, sat_mode_q, ovf_trk_q, ovf_q;
    logic [IW-1:0]          i_q, j_q, k_q;
    logic signed [AW-1:0]   acc_q, base, sum;
    logic signed [W-1:0]    a_el, b_el, c_el, red;
    logic signed [2*W-1:0]  prod;
    logic                   k_last, last, over, under, busy, done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        a_el   = a_q[(int'(i_q) * N + int'(k_q)) * W +: W];
        b_el   = b_q[(int'(k_q) * N + int'(j_q)) * W +: W];
        c_el   = mat_c_q[(int'(i_q) * N + int'(j_q)) * W +: W];
        prod   = a_el * b_el;
        k_last = (k_q == LAST);
        last   = k_last && (j_q == LAST) && (i_q == LAST);
        if (k_q == '0)
            base = acc_mode_q ? {{(AW - W){c_el[W-1]}}, c_el} : '0;
        else
            base = acc_q;
        sum   = base + {{(AW - 2 * W){prod[2*W-1]}}, prod};
        over  = (sum > MAXV);
        under = (sum < MINV);
        red   = sum[W-1:0];
        if (sat_mode_q && over)  red = MAXV[W-1:0];
        if (sat_mode_q && under) red = MINV[W-1:0];
        shadow_d = shadow_q;
        if (k_last) shadow_d[(int'(i_q) * N + int'(j_q)) * W +: W] = red;
    end

    // The final element is merged via shadow_d so mat_c updates in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            acc_mode_q <= 1'b0;
            sat_mode_q <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            shadow_q   <= '0;
            mat_c_q    <= '0;
            ovf_trk_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                a_q        <= bus.mat_a;
                b_q        <= bus.mat_b;
                acc_mode_q <= bus.acc_mode;
                sat_mode_q <= bus.sat_mode;
                i_q        <= '0;
                j_q        <= '0;
                k_q        <= '0;
                ovf_trk_q  <= 1'b0;
            end
        end else if (state_q == RUN) begin
            acc_q    <= sum;
            shadow_q <= shadow_d;
            if (k_last) begin
                k_q       <= '0;
                ovf_trk_q <= ovf_trk_q | over | under;
                if (j_q == LAST) begin
                    j_q <= '0;
                    i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
            if (last) begin
                mat_c_q <= shadow_d;
                ovf_q   <= ovf_trk_q | over | under;
            end
        end
    end

    assign bus.mat_c = mat_c_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = busy;
    assign bus.done  = done;
endmodule

// File: tb/tb_mmul_param.sv
// Scoreboard bench for mmul_param (N=3, W=8): directed products, timing,
// ignored start, mid-run reset.
module tb_mmul_param;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int NN = N * N * W;
    localparam int N3 = N * N * N;

    typedef struct {
        logic [NN-1:0] c;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   dones  = 0;
    exp_t exp_q[$];

    mmul_param_if #(.N(N), .W(W)) bus ();

    mmul_param #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NN-1:0] act, input logic [NN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            dones++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mat_c", bus.mat_c, e.c);
                chk("ovf", NN'(bus.ovf), NN'(e.ovf));
            end
        end
    end

    function automatic logic [NN-1:0] fill(input logic [W-1:0] v);
        logic [NN-1:0] m;
        for (int unsigned x = 0; x < N * N; x++) m[x*W +: W] = v;
        return m;
    endfunction

    task automatic run_op(input logic [NN-1:0] a, input logic [NN-1:0] b,
                          input logic acc, input logic sat,
                          input logic [NN-1:0] exp_c, input logic exp_ovf,
                          input bit timing, input bit poke);
        exp_t e;
        @(negedge clk);
        bus.mat_a    = a;
        bus.mat_b    = b;
        bus.acc_mode = acc;
        bus.sat_mode = sat;
        bus.start    = 1'b1;
        e.c   = exp_c;
        e.ovf = exp_ovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int e_i = 1; e_i <= N3 + 1; e_i++) begin
            @(posedge clk);
            #1;
            if (timing) begin
                chk($sformatf("busy@%0d", e_i), NN'(bus.busy), NN'(e_i <= N3));
                chk($sformatf("done@%0d", e_i), NN'(bus.done), NN'(e_i == N3));
            end
            if (poke && e_i == 3) begin
                bus.mat_a    = fill(8'h55);
                bus.mat_b    = fill(8'hAA);
                bus.acc_mode = ~acc;
                bus.sat_mode = ~sat;
            end
            if (poke && e_i == 4) bus.start = 1'b1;
            if (poke && e_i == 5) bus.start = 1'b0;
        end
        chk("idle_after_op", NN'(bus.busy), NN'(0));
    endtask

    logic [NN-1:0] ident, seq9, seq2x, all7f, all80;

    initial begin
        ident = '0;
        for (int unsigned r = 0; r < N; r++) ident[(r*N+r)*W +: W] = 8'd1;
        for (int unsigned x = 0; x < N * N; x++) begin
            seq9[x*W +: W]  = W'(x + 1);
            seq2x[x*W +: W] = W'(2 * (x + 1));
        end
        all7f = fill(8'h7F);
        all80 = fill(8'h80);

        bus.start = 1'b0; bus.acc_mode = 1'b0; bus.sat_mode = 1'b0;
        bus.mat_a = '0;   bus.mat_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", NN'(bus.busy), NN'(0));
        chk("rst_done", NN'(bus.done), NN'(0));
        chk("rst_ovf", NN'(bus.ovf), NN'(0));
        chk("rst_mat_c", bus.mat_c, '0);
        @(negedge clk) rst = 1'b0;

        run_op(ident, seq9, 1'b0, 1'b0, seq9, 1'b0, 1'b1, 1'b0);
        run_op(ident, seq9, 1'b1, 1'b0, seq2x, 1'b0, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1 chk("hold_mat_c", bus.mat_c, seq2x);
        // 3*127*127 = 48387: saturates to 127, wraps to 0x03
        run_op(all7f, all7f, 1'b0, 1'b1, fill(8'h7F), 1'b1, 1'b0, 1'b1);
        run_op(all7f, all7f, 1'b0, 1'b0, fill(8'h03), 1'b1, 1'b0, 1'b0);
        // 3*(-128)*(-128) = 49152: saturates to 127, wraps to 0x00
        run_op(all80, all80, 1'b0, 1'b1, fill(8'h7F), 1'b1, 1'b0, 1'b0);
        run_op(all80, all80, 1'b0, 1'b0, fill(8'h00), 1'b1, 1'b0, 1'b0);
        run_op(ident, seq9, 1'b0, 1'b0, seq9, 1'b0, 1'b0, 1'b0);
        #1 chk("ovf_cleared", NN'(bus.ovf), NN'(0));

        // Abandoned run: reset after edge 10, no done, mat_c cleared at once.
        @(negedge clk);
        bus.mat_a = all7f; bus.mat_b = all7f; bus.acc_mode = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", NN'(bus.busy), NN'(0));
        chk("midrst_done", NN'(bus.done), NN'(0));
        chk("midrst_mat_c", bus.mat_c, '0);
        chk("midrst_ovf", NN'(bus.ovf), NN'(0));
        @(negedge clk) rst = 1'b0;
        // acc_mode=1 after reset accumulates onto the cleared mat_c
        run_op(ident, seq9, 1'b1, 1'b0, seq9, 1'b0, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_results", NN'(exp_q.size()), NN'(0));
        chk("done_count", NN'(dones), NN'(8));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
